// File: rtl/med_pkg.sv
// Shared constants, FSM state type and the compute-phase BYP schedule for the
// 3x3 median unit.
package med_pkg;

  localparam int DATA_W_DEF     = 8;
  localparam int N_SAMPLES      = 9;
  localparam int N_PASSES       = 4;
  localparam int COMPUTE_CYCLES = 40;
  localparam int SCNT_W         = 4;
  localparam int CCNT_W         = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2,
    CAPT    = 2'd3
  } state_e;

  // Pass p spans 9 cycles: (8-p) compares, then (p+1) bypasses; the last 4 cycles compare.
  function automatic logic byp_of(input logic [CCNT_W-1:0] ccnt);
    int   c;
    int   base;
    logic b;
    c    = int'(ccnt);
    base = 0;
    b    = 1'b0;
    for (int p = 0; p < N_PASSES; p++) begin
      if ((c >= base + N_SAMPLES - 1 - p) && (c < base + N_SAMPLES)) b = 1'b1;
      base = base + N_SAMPLES;
    end
    return b;
  endfunction

endpackage

// File: rtl/median_seq_med.sv
// MED compare/shift datapath: a hold register plus an 8-deep chain forming a
// 9-element loop. BYP=1 loads DI into the chain; BYP=0 bubbles the max into hold.
module median_seq_med
  import med_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic [DATA_W-1:0] di_i,
  input  logic              byp_i,
  output logic [DATA_W-1:0] do_o
);

  logic [DATA_W-1:0] hold_q;
  logic [DATA_W-1:0] chain_q [N_SAMPLES-1];
  logic [DATA_W-1:0] tail;
  logic [DATA_W-1:0] hi_val;
  logic [DATA_W-1:0] lo_val;

  assign tail   = chain_q[N_SAMPLES-2];
  assign hi_val = (tail > hold_q) ? tail : hold_q;
  assign lo_val = (tail > hold_q) ? hold_q : tail;
  assign do_o   = hold_q;

  // On bypass the held value is dropped; during compute that discards each pass's maximum.
  always_ff @(posedge clk_i) begin
    if (byp_i) begin
      hold_q     <= tail;
      chain_q[0] <= di_i;
    end else begin
      hold_q     <= hi_val;
      chain_q[0] <= lo_val;
    end
    for (int i = 1; i < N_SAMPLES - 1; i++) begin
      chain_q[i] <= chain_q[i-1];
    end
  end

endmodule

// File: rtl/median_seq.sv
// Sequencer wrapping the MED datapath into a self-contained 3x3 median unit.
// state   | meaning
// IDLE    | waiting for a DSI rising edge; MED keeps loading
// LOAD    | collecting samples 2..9 while DSI stays high
// COMPUTE | 40 cycles of scheduled compare/bypass
// CAPT    | register the median and pulse DSO
module median_seq
  import med_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] di_i,
  input  logic              dsi_i,
  output logic [DATA_W-1:0] do_o,
  output logic              dso_o,
  output logic              busy_o
);

  state_e            state_q, state_d;
  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic [CCNT_W-1:0] ccnt_q, ccnt_d;
  logic [DATA_W-1:0] do_q, do_d;
  logic              dso_q, dso_d;
  logic              dsi_q;
  logic              byp;
  logic [DATA_W-1:0] med_do;

  median_seq_med #(.DATA_W(DATA_W)) u_med (
    .clk_i (clk_i),
    .di_i  (di_i),
    .byp_i (byp),
    .do_o  (med_do)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      scnt_q  <= '0;
      ccnt_q  <= '0;
      do_q    <= '0;
      dso_q   <= 1'b0;
      dsi_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      ccnt_q  <= ccnt_d;
      do_q    <= do_d;
      dso_q   <= dso_d;
      dsi_q   <= dsi_i;
    end
  end

  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    ccnt_d  = ccnt_q;
    do_d    = do_q;
    dso_d   = 1'b0;
    byp     = 1'b1;
    busy_o  = 1'b1;
    case (state_q)
      IDLE: begin
        busy_o = 1'b0;
        if (dsi_i && !dsi_q) begin
          state_d = LOAD;
          scnt_d  = SCNT_W'(1);
        end
      end
      LOAD: begin
        if (dsi_i) begin
          scnt_d = scnt_q + SCNT_W'(1);
          if (scnt_q == SCNT_W'(N_SAMPLES - 1)) begin
            state_d = COMPUTE;
            ccnt_d  = '0;
          end
        end else begin
          state_d = IDLE;
          scnt_d  = '0;
        end
      end
      COMPUTE: begin
        byp    = byp_of(ccnt_q);
        ccnt_d = ccnt_q + CCNT_W'(1);
        if (ccnt_q == CCNT_W'(COMPUTE_CYCLES - 1)) state_d = CAPT;
      end
      CAPT: begin
        do_d    = med_do;
        dso_d   = 1'b1;
        state_d = IDLE;
        scnt_d  = '0;
        ccnt_d  = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign do_o  = do_q;
  assign dso_o = dso_q;

endmodule

// File: tb/tb_median_seq.sv
// Directed and random-window bench for median_seq.
module tb_median_seq;
  import med_pkg::*;

  logic       clk;
  logic       rst;
  logic [7:0] di;
  logic       dsi;
  logic [7:0] dout;
  logic       dso;
  logic       busy;

  int   checks = 0;
  int   errors = 0;
  logic byp_exp [COMPUTE_CYCLES];
  localparam int RUNS [9] = '{8, 1, 7, 2, 6, 3, 5, 4, 4};

  median_seq #(.DATA_W(8)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .di_i   (di),
    .dsi_i  (dsi),
    .do_o   (dout),
    .dso_o  (dso),
    .busy_o (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // w[8] is the first sample, w[0] the ninth.
  task automatic load9(input logic [8:0][7:0] w, input string tag, input bit chk_busy);
    for (int i = 0; i < 9; i++) begin
      di  = w[8-i];
      dsi = 1'b1;
      tick();
      if (i == 0 && chk_busy) chk({tag, "_busy_load"}, 32'(busy), 32'd1);
    end
  endtask

  task automatic run_window(input logic [8:0][7:0] w, input logic [7:0] exp_med,
                            input string tag, input bit probe, input int dsi_hi,
                            input bit pulse, input bit quick);
    int lat;
    load9(w, tag, !quick);
    lat = 0;
    for (int n = 1; n <= 60; n++) begin
      if (probe && n <= COMPUTE_CYCLES) begin
        chk("byp_pkg", 32'(dut.byp), 32'(byp_of(6'(n - 1))));
        chk("byp_tbl", 32'(dut.byp), 32'(byp_exp[n-1]));
      end
      dsi = (n <= dsi_hi) || (pulse && n >= 10 && n <= 30 && (n % 3) == 0);
      di  = 8'($urandom);
      tick();
      if (dso) begin
        lat = n;
        break;
      end
    end
    chk({tag, "_latency"}, 32'(lat), 32'd41);
    chk({tag, "_median"}, 32'(dout), 32'(exp_med));
    chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
    if (!quick) begin
      tick();
      chk({tag, "_dso_width"}, 32'(dso), 32'd0);
      repeat (4) tick();
      chk({tag, "_no_restart"}, 32'(busy), 32'd0);
      dsi = 1'b0;
      tick();
    end else begin
      dsi = 1'b0;
    end
  endtask

  initial begin
    int idx;
    int nd;
    logic [8:0][7:0] w;
    logic [7:0] a [9];
    logic [7:0] t;
    logic v;

    idx = 0;
    v   = 1'b0;
    for (int r = 0; r < 9; r++) begin
      for (int j = 0; j < RUNS[r]; j++) begin
        byp_exp[idx] = v;
        idx++;
      end
      v = ~v;
    end

    rst = 1'b1;
    dsi = 1'b0;
    di  = '0;
    repeat (3) tick();
    chk("reset_do", 32'(dout), 32'd0);
    chk("reset_dso", 32'(dso), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();

    run_window({8'd90, 8'd10, 8'd50, 8'd30, 8'd70, 8'd20, 8'd80, 8'd40, 8'd60}, 8'd50, "winA", 1'b1, 0, 1'b0, 1'b0);
    run_window({8'd0, 8'd0, 8'd0, 8'd0, 8'd7, 8'd9, 8'd9, 8'd9, 8'd9}, 8'd7, "dups", 1'b0, 0, 1'b0, 1'b0);
    run_window({9{8'd255}}, 8'd255, "all255", 1'b0, 0, 1'b0, 1'b0);

    // Reset three cycles in the middle of COMPUTE: window must vanish without a strobe.
    load9({9{8'd200}}, "rstwin", 1'b0);
    dsi = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    chk("midrst_do", 32'(dout), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_dso", 32'(dso), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    nd  = 0;
    repeat (60) begin
      tick();
      if (dso) nd++;
    end
    chk("midrst_no_dso", 32'(nd), 32'd0);
    run_window({8'd90, 8'd10, 8'd50, 8'd30, 8'd70, 8'd20, 8'd80, 8'd40, 8'd60}, 8'd50, "after_rst", 1'b0, 0, 1'b0, 1'b0);

    run_window({9{8'd0}}, 8'd0, "all0", 1'b0, 0, 1'b0, 1'b0);
    run_window({8'd5, 8'd1, 8'd4, 8'd2, 8'd3, 8'd9, 8'd8, 8'd7, 8'd6}, 8'd5, "held12", 1'b0, 3, 1'b0, 1'b0);
    run_window({8'd3, 8'd3, 8'd8, 8'd1, 8'd6, 8'd6, 8'd2, 8'd9, 8'd4}, 8'd4, "pulse", 1'b0, 0, 1'b1, 1'b0);
    run_window({8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90}, 8'd50, "hold_idle", 1'b0, 50, 1'b0, 1'b0);

    // DSI drops after five samples.
    for (int i = 0; i < 5; i++) begin
      di  = 8'(i + 1);
      dsi = 1'b1;
      tick();
    end
    dsi = 1'b0;
    tick();
    chk("abort_idle", 32'(busy), 32'd0);
    nd = 0;
    repeat (60) begin
      tick();
      if (dso) nd++;
    end
    chk("abort_no_dso", 32'(nd), 32'd0);
    chk("abort_do_kept", 32'(dout), 32'd50);

    // Back-to-back random windows at the 50-cycle minimum period.
    for (int wi = 0; wi < 1000; wi++) begin
      for (int i = 0; i < 9; i++) begin
        a[i]    = 8'($urandom);
        w[8-i]  = a[i];
      end
      for (int i = 1; i < 9; i++) begin
        for (int j = i; j > 0; j--) begin
          if (a[j] < a[j-1]) begin
            t      = a[j];
            a[j]   = a[j-1];
            a[j-1] = t;
          end
        end
      end
      run_window(w, a[4], "rand", 1'b0, 0, 1'b0, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/median_seq.md
Name: median_seq

Overview:
- Sequencer and wrapper that turns the MED compare/shift datapath into a self-contained 3x3 median unit.
- Accepts a 9-sample window framed by DSI and generates MED's BYP schedule internally.
- Registers the median and flags it with a one-cycle DSO strobe.
- Sits between the pixel/window source and downstream consumers; MED's BYP becomes internal.

Parameters:
- DATA_W, 8, sample width; must equal the MED datapath width.

Ports:
- CLK   in   1       clock; all logic on rising edge
- RST   in   1       synchronous, active-high reset
- DI    in   DATA_W  input sample, sampled on edges where DSI=1 and a window is loading
- DSI   in   1       window valid; 9 consecutive high cycles frame one window
- DO    out  DATA_W  registered median of the last completed window
- DSO   out  1       one-cycle strobe: DO holds a new median
- BUSY  out  1       high from first sample until DSO; new windows are not accepted while high

Behaviour:
- Clocking and reset:
  - One clock (CLK). Reset (RST) is synchronous and active-high.
  - Reset values: DO=0, DSO=0, BUSY=0, state=IDLE, counters=0.
  - RST in any state, including mid-LOAD or mid-COMPUTE, aborts the window with no DSO.
- MED instance wiring: DI and CLK shared; BYP driven by this block; MED.DO feeds the output register. MED shifts every cycle; there is no enable.
- FSM states: IDLE, LOAD, COMPUTE, CAPT.
- IDLE:
  - BYP=1, BUSY=0.
  - On an edge with DSI=1 and dsi_q=0 (DSI rising; dsi_q is DSI registered), sample 1 is captured. Go to LOAD with scnt=1.
  - DSI held high across IDLE does not start a window.
- LOAD:
  - BYP=1, BUSY=1.
  - Each edge with DSI=1 increments scnt.
  - When the 9th sample is captured (edge E0), go to COMPUTE with ccnt=0.
  - DSI=0 in LOAD with scnt<9 aborts: go to IDLE, no DSO, DO unchanged.
- COMPUTE: exactly 40 cycles, ccnt 0..39, BUSY=1. BYP is a function of ccnt, in ccnt order:
  - 8 cycles 0, then 1 cycle 1
  - 7 cycles 0, then 2 cycles 1
  - 6 cycles 0, then 3 cycles 1
  - 5 cycles 0, then 4 cycles 1
  - 4 cycles 0
  - Equivalent pass form: pass p=0..3 is (8-p) cycles BYP=0 followed by (p+1) cycles BYP=1, then a final 4 cycles BYP=0.
  - After edge E40, MED.DO equals the median. Go to CAPT.
- CAPT:
  - BYP=1, BUSY=1.
  - At edge E41: DO <= MED.DO, DSO <= 1, go to IDLE.
  - DSO is high for exactly the cycle E41–E42 and low otherwise.
- Latency: 41 edges from the 9th-sample edge to DSO rising. Minimum window period is 50 cycles: 9 load + 40 compute + 1 capture.
- Boundary conditions:
  - DSI activity while BUSY=1 after LOAD (i.e. in COMPUTE/CAPT) is ignored.
  - DSI still high on return to IDLE requires a 0 before a new rising edge is accepted.
  - DSI high for more than 9 cycles: extra samples are ignored; the window is the first 9.
  - DSO and a new DSI rise on the same edge are legal: the first sample of the next window is accepted at E42 at the earliest (DSI rises in the cycle following E41).
- Arithmetic: unsigned compares inside MED; median is exact for duplicates; no rounding.
- Counter widths: scnt 4 bits, ccnt 6 bits; neither wraps in normal operation.

Decomposition:
- Package med_pkg holds:
  - N_SAMPLES=9, N_PASSES=4, COMPUTE_CYCLES=40, DATA_W default
  - state typedef enum {IDLE, LOAD, COMPUTE, CAPT}
  - function byp_of(ccnt) returning the schedule bit; shared with the bench
- One sub-module: the existing MED datapath, instantiated unmodified.
- The FSM and BYP decode stay in median_seq.

Test Plan:
- Reset: assert RST 3 cycles mid-COMPUTE of a window -> DO=0, DSO=0, BUSY=0 next cycle; no DSO ever for that window; the next window completes correctly.
- Window 90,10,50,30,70,20,80,40,60 -> DSO high exactly 1 cycle, 41 edges after the 9th sample edge; DO=50; BUSY falls with DSO.
- Duplicates and extremes:
  - {0,0,0,0,7,9,9,9,9} -> DO=7
  - all 255 -> DO=255
  - all 0 -> DO=0
- BYP probe during COMPUTE must match 0x8,1x1,0x7,1x2,0x6,1x3,0x5,1x4,0x4. Bench checks against med_pkg::byp_of.
- DSI framing:
  - DSI drops after 5 samples -> no DSO, return to IDLE.
  - DSI pulses during COMPUTE -> ignored.
  - DSI held 12 cycles -> median of the first 9 only.
- 1000 random windows issued back-to-back at the 50-cycle minimum period -> each DO equals the sorted-reference median; zero mismatches.
